// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
// Optional checksum state is present only with IMEM_LOADER_CSUM_EN.
package imem_loader_pkg;

   localparam logic [7:0] LOADER_MAGIC = 8'hA5;
   localparam int         CSUM_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
`ifdef IMEM_LOADER_CSUM_EN
      ST_CSUM   = 3'd4,
`endif
      ST_DRAIN  = 3'd5,
      ST_RUN    = 3'd6,
      ST_ERROR  = 3'd7
   } loader_state_t;

endpackage

// File: rtl/imem_loader_packer.sv
// Byte-to-word packer: little-endian lane placement, 4th byte strobes a word.
// The completed word is presented combinationally with the final byte.
module byte_to_word_packer (
   input  logic        clk,
   input  logic        reset,
   input  logic        byte_vld_i,
   input  logic        clr_i,
   input  logic [7:0]  byte_i,
   output logic        word_vld_o,
   output logic [31:0] word_o
);

   logic [1:0]  cnt_q;
   logic [23:0] lane_q;

   // byte counter and storage for the three lower lanes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q  <= 2'd0;
         lane_q <= 24'd0;
      end else if (clr_i) begin
         cnt_q  <= 2'd0;
      end else if (byte_vld_i) begin
         cnt_q <= cnt_q + 2'd1;
         unique case (cnt_q)
            2'd0: lane_q[7:0]   <= byte_i;
            2'd1: lane_q[15:8]  <= byte_i;
            2'd2: lane_q[23:16] <= byte_i;
            2'd3: ;
         endcase
      end
   end

   assign word_vld_o = byte_vld_i && (cnt_q == 2'd3);
   assign word_o     = {byte_i, lane_q};

endmodule

// File: rtl/imem_loader.sv
// Framed byte-stream loader into instruction memory; holds core in reset.
// Define IMEM_LOADER_CSUM_EN to require a trailing mod-256 checksum byte.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int IMEM_DEPTH_WORDS = 256,
   parameter int ADDR_W           = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              core_reset,
   output logic              load_done,
   output logic              load_error
);

   localparam int WIDX_W = $clog2(IMEM_DEPTH_WORDS) + 1;

`ifdef IMEM_LOADER_CSUM_EN
   localparam loader_state_t ST_TAIL = ST_CSUM;
`else
   localparam loader_state_t ST_TAIL = ST_DRAIN;
`endif

   loader_state_t     state_q, state_d;
   logic [15:0]       len_q, len_d;
   logic [WIDX_W-1:0] widx_q, widx_d, widx_inc;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              crst_q, crst_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
`ifdef IMEM_LOADER_CSUM_EN
   logic [CSUM_W-1:0] csum_q, csum_d;
`endif

   logic        rdy;
   logic        xfer;
   logic        in_data;
   logic        word_vld;
   logic [31:0] word;
   logic [15:0] n_full;

   assign xfer     = rx_valid && rdy;
   assign in_data  = (state_q == ST_DATA);
   assign widx_inc = widx_q + WIDX_W'(1);
   assign n_full   = {rx_data, len_q[7:0]};

   byte_to_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .byte_vld_i (xfer && in_data),
      .clr_i      (!in_data),
      .byte_i     (rx_data),
      .word_vld_o (word_vld),
      .word_o     (word)
   );

   // ready decode: the loader accepts bytes only while parsing a frame
   always_comb begin
      rdy = 1'b0;
      unique case (state_q)
         ST_IDLE,
         ST_LEN_LO,
         ST_LEN_HI,
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM,
`endif
         ST_DATA:  rdy = 1'b1;
         default:  rdy = 1'b0;
      endcase
   end

   // frame parser, length check, write generation and core release
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      widx_d  = widx_q;
      we_d    = 1'b0;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      crst_d  = crst_q;
      done_d  = done_q;
      err_d   = err_q;
`ifdef IMEM_LOADER_CSUM_EN
      csum_d  = csum_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (xfer && rx_data == LOADER_MAGIC)
               state_d = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (xfer) begin
               len_d   = {len_q[15:8], rx_data};
               state_d = ST_LEN_HI;
            end
         end
         ST_LEN_HI: begin
            if (xfer) begin
               len_d  = n_full;
               widx_d = '0;
               if (32'(n_full) > 32'(IMEM_DEPTH_WORDS)) begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end else if (n_full == 16'd0) begin
                  state_d = ST_TAIL;
               end else begin
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
            if (xfer)
               csum_d = csum_q + rx_data;
`endif
            if (word_vld) begin
               we_d    = 1'b1;
               addr_d  = ADDR_W'({widx_q, 2'b00});
               wdata_d = word;
               widx_d  = widx_inc;
               if (32'(widx_inc) == 32'(len_q))
                  state_d = ST_TAIL;
            end
         end
`ifdef IMEM_LOADER_CSUM_EN
         ST_CSUM: begin
            if (xfer) begin
               if (rx_data == csum_q) begin
                  state_d = ST_DRAIN;
               end else begin
                  state_d = ST_ERROR;
                  err_d   = 1'b1;
               end
            end
         end
`endif
         ST_DRAIN: begin
            state_d = ST_RUN;
            crst_d  = 1'b0;
            done_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // state and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         len_q   <= 16'd0;
         widx_q  <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= 32'd0;
         crst_q  <= 1'b1;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         widx_q  <= widx_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         crst_q  <= crst_d;
         done_q  <= done_d;
         err_q   <= err_d;
`ifdef IMEM_LOADER_CSUM_EN
         csum_q  <= csum_d;
`endif
      end
   end

   assign rx_ready   = rdy;
   assign imem_we    = we_q;
   assign imem_addr  = addr_q;
   assign imem_wdata = wdata_q;
   assign core_reset = crst_q;
   assign load_done  = done_q;
   assign load_error = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a small write-capturing memory model.
// Checksum bytes are sent only when IMEM_LOADER_CSUM_EN is defined.
module tb_imem_loader;

`ifdef IMEM_LOADER_CSUM_EN
   localparam bit CS_ON = 1'b1;
`else
   localparam bit CS_ON = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic        imem_we;
   logic [31:0] imem_addr;
   logic [31:0] imem_wdata;
   logic        core_reset;
   logic        load_done;
   logic        load_error;

   int vec = 0;
   int errs = 0;
   int nw = 0;
   int base = 0;
   logic [31:0] mem [0:255];

   imem_loader #(.IMEM_DEPTH_WORDS(256), .ADDR_W(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_ready   (rx_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .core_reset (core_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clk = ~clk;

   // instruction memory model: captures a word on each strobed edge
   always @(posedge clk) begin
      if (reset && imem_we) begin
         mem[imem_addr[9:2]] = imem_wdata;
         nw++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_data  = b;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_rst(input string tag);
      chk({tag, "_rdy"},  32'(rx_ready),   32'd1);
      chk({tag, "_we"},   32'(imem_we),    32'd0);
      chk({tag, "_addr"}, imem_addr,       32'd0);
      chk({tag, "_wd"},   imem_wdata,      32'd0);
      chk({tag, "_crst"}, 32'(core_reset), 32'd1);
      chk({tag, "_done"}, 32'(load_done),  32'd0);
      chk({tag, "_err"},  32'(load_error), 32'd0);
   endtask

   task automatic do_reset();
      rx_valid = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      base = nw;
   endtask

   // called just after the final frame byte is accepted (DRAIN entered)
   task automatic chk_release(input string tag);
      rx_valid = 1'b0;
      chk({tag, "_drain_rdy"},  32'(rx_ready),   32'd0);
      chk({tag, "_drain_crst"}, 32'(core_reset), 32'd1);
      chk({tag, "_drain_done"}, 32'(load_done),  32'd0);
      @(posedge clk);
      #1;
      chk({tag, "_run_crst"}, 32'(core_reset), 32'd0);
      chk({tag, "_run_done"}, 32'(load_done),  32'd1);
      chk({tag, "_run_err"},  32'(load_error), 32'd0);
   endtask

   initial begin
      reset    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      #12;
      chk_rst("por");
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      base = nw;

      // two-word frame, back-to-back bytes
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      chk("w0_we",   32'(imem_we), 32'd1);
      chk("w0_addr", imem_addr,    32'h0);
      chk("w0_data", imem_wdata,   32'h0000_0013);
      send(8'h93);
      chk("w0_we_1cyc", 32'(imem_we), 32'd0);
      send(8'h00); send(8'h10); send(8'h00);
      chk("w1_we",   32'(imem_we), 32'd1);
      chk("w1_addr", imem_addr,    32'h4);
      chk("w1_data", imem_wdata,   32'h0010_0093);
      if (CS_ON) send(8'hB6);
      chk_release("f2");
      chk("f2_nw",   32'(nw - base), 32'd2);
      chk("f2_mem0", mem[0],         32'h0000_0013);
      chk("f2_mem1", mem[1],         32'h0010_0093);

      // bytes presented in RUN are never consumed
      rx_valid = 1'b1;
      rx_data  = 8'hA5;
      repeat (3) @(posedge clk);
      #1;
      chk("run_rdy",  32'(rx_ready),   32'd0);
      chk("run_nw",   32'(nw - base),  32'd2);
      chk("run_done", 32'(load_done),  32'd1);
      rx_valid = 1'b0;

`ifdef IMEM_LOADER_CSUM_EN
      // bad checksum: writes happen, then sticky error
      do_reset();
      send(8'hA5); send(8'h02); send(8'h00);
      send(8'h13); send(8'h00); send(8'h00); send(8'h00);
      send(8'h93); send(8'h00); send(8'h10); send(8'h00);
      send(8'h00);
      rx_valid = 1'b0;
      chk("bcs_err",  32'(load_error), 32'd1);
      chk("bcs_rdy",  32'(rx_ready),   32'd0);
      @(posedge clk);
      #1;
      chk("bcs_crst", 32'(core_reset), 32'd1);
      chk("bcs_nw",   32'(nw - base),  32'd2);
`endif

      // junk before magic, zero-length frame
      do_reset();
      send(8'h11); send(8'hFF);
      send(8'hA5); send(8'h00); send(8'h00);
      if (CS_ON) send(8'h00);
      chk_release("z0");
      chk("z0_nw", 32'(nw - base), 32'd0);

      // oversize length 257
      do_reset();
      send(8'hA5); send(8'h01); send(8'h01);
      rx_valid = 1'b0;
      chk("big_err",  32'(load_error), 32'd1);
      chk("big_rdy",  32'(rx_ready),   32'd0);
      chk("big_crst", 32'(core_reset), 32'd1);
      @(posedge clk);
      #1;
      chk("big_sticky", 32'(load_error), 32'd1);
      chk("big_nw",     32'(nw - base),  32'd0);

      // asynchronous reset mid-frame, then a fresh one-word frame
      do_reset();
      send(8'hA5); send(8'h03); send(8'h00);
      send(8'h01); send(8'h02); send(8'h03); send(8'h04);
      send(8'h05); send(8'h06);
      chk("mid_nw",   32'(nw - base), 32'd1);
      chk("mid_mem0", mem[0],         32'h0403_0201);
      #2;
      reset = 1'b0;
      #1;
      chk_rst("midrst");
      rx_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      base = nw;
      send(8'hA5); send(8'h01); send(8'h00);
      send(8'hEF); send(8'hBE); send(8'hAD); send(8'hDE);
      chk("one_addr", imem_addr,  32'h0);
      chk("one_data", imem_wdata, 32'hDEAD_BEEF);
      if (CS_ON) send(8'h38);
      chk_release("one");
      chk("one_nw",   32'(nw - base), 32'd1);
      chk("one_mem0", mem[0],         32'hDEAD_BEEF);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
